ram_table_master: RTL and testbench

- Initiator-side controller for a single-port 128x32 coefficient RAM with synchronous write and asynchronous (combinational) read.
- Accepts block commands (base address, length, direction).
- Write commands fill the RAM from an input valid/ready stream. Read commands stream RAM words out on an output valid/ready stream.
- Sits between the table loader / function-evaluation datapath and the RAM, and is the only driver of the RAM's we, address and d pins.

---
 rtl/ram_table_master.sv | 113 +++++++++++
 tb/tb_ram_table_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_table_master.sv
// Block-transfer controller for a single-port coefficient RAM. It fills the RAM
// from a write stream, or streams RAM words out through a registered read port.
module ram_table_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  rd_load;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign wr_ready    = (state == WRITE);
  assign ram_we      = wr_ready & wr_valid;
  assign ram_address = ptr;
  assign ram_d       = wr_data;

  // The output register may take a new word when it is empty or being drained.
  assign rd_load = !rd_valid || rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_base;
            remaining <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_write) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        // Address wraps naturally through the ADDR_WIDTH-bit pointer.
        READ: begin
          if (rd_load) begin
            rd_data   <= ram_q;
            rd_valid  <= 1'b1;
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            state    <= DONE;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_table_master.sv
// Bench for ram_table_master: a behavioural RAM plus a queue-based model that
// predicts every RAM write and every read-stream word from the commands issued.
module tb_ram_table_master;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          busy;
  logic          done;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  ram_table_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q)
  );

  // Behavioural RAM: synchronous write, combinational read, preloaded once.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          mem_loaded = 1'b0;
  assign ram_q = mem[ram_address];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_address] <= ram_d;
    end
  end

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] wr_plan[$];
  logic [DW-1:0] wr_feed[$];
  logic [DW-1:0] rd_log[$];
  bit            rd_pat[$];

  int ncyc = 0, acc_cnt = 0, acc_n = 0, done_cnt = 0, done_n = 0;
  int we_cnt = 0, xfer_cnt = 0, cmd_xfers = 0, stall_cnt = 0;
  int first_valid_n = 0, first_xfer_n = 0, last_xfer_n = 0;
  int gap_cnt = 0, rd_idx = 0;
  bit seen_valid = 0, model_active = 0, prev_stall = 0, wr_pop = 0, gap_mode = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Write-stream source: presents queued words, optionally with periodic gaps.
  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (wr_pop) begin
        if (wr_feed.size() > 0) wr_feed.delete(0);
        wr_pop = 0;
      end
      gap_cnt++;
      if (wr_feed.size() > 0 && !(gap_mode && (gap_cnt % 3 == 0))) begin
        wr_valid = 1'b1;
        wr_data  = wr_feed[0];
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  // Read-stream sink: follows a ready pattern when one is loaded, else always ready.
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rd_idx < rd_pat.size()) begin
        rd_ready = rd_pat[rd_idx];
        rd_idx++;
      end else begin
        rd_ready = 1'b1;
      end
    end
  end

  // Compare process: samples mid-cycle, i.e. the values the next rising edge will act on.
  always @(negedge clk) begin
    int            eff;
    logic [AW-1:0] a;
    bit            pend;
    if (rst_n) begin
      ncyc++;
      pend = (exp_wa.size() > 0);
      checkOutput("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      checkOutput("write_beat", 32'(ram_we), 32'(wr_valid && pend));
      if (ram_we && pend) begin
        we_cnt++;
        checkOutput("write_addr", 32'(ram_address), 32'(exp_wa[0]));
        checkOutput("write_data", ram_d, exp_wd[0]);
        model_mem[exp_wa[0]] = exp_wd[0];
        exp_wa.delete(0);
        exp_wd.delete(0);
      end else if (ram_we) begin
        we_cnt++;
      end
      if (wr_valid && wr_ready) wr_pop = 1;
      if (cmd_valid && cmd_ready) begin
        eff = (cmd_len > 8'd128) ? DEPTH : int'(cmd_len);
        acc_cnt++;
        acc_n        = ncyc;
        seen_valid   = 0;
        cmd_xfers    = 0;
        model_active = 1;
        for (int i = 0; i < eff; i++) begin
          a = AW'((int'(cmd_base) + i) % DEPTH);
          if (cmd_write) begin
            if (wr_plan.size() > 0) begin
              exp_wa.push_back(a);
              exp_wd.push_back(wr_plan[0]);
              wr_plan.delete(0);
            end
          end else begin
            exp_rd.push_back(model_mem[a]);
          end
        end
      end
      if (rd_valid && rd_ready) begin
        xfer_cnt++;
        if (cmd_xfers == 0) first_xfer_n = ncyc;
        cmd_xfers++;
        last_xfer_n = ncyc;
        rd_log.push_back(rd_data);
        checkOutput("read_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) begin
          checkOutput("read_data", rd_data, exp_rd[0]);
          exp_rd.delete(0);
        end
      end
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(rd_valid), 32'd1);
        checkOutput("hold_data", rd_data, prev_data);
      end
      prev_stall = rd_valid && !rd_ready;
      if (prev_stall) stall_cnt++;
      prev_data = rd_data;
      if (rd_valid && !seen_valid) begin
        seen_valid    = 1;
        first_valid_n = ncyc;
      end
      if (done) begin
        done_cnt++;
        done_n = ncyc;
        checkOutput("done_while_active", 32'(model_active), 32'd1);
        checkOutput("done_writes_left", 32'(exp_wa.size()), 32'd0);
        checkOutput("done_reads_left", 32'(exp_rd.size()), 32'd0);
        model_active = 0;
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic queueWords(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_plan.push_back(first + 32'(i));
      wr_feed.push_back(first + 32'(i));
    end
  endtask

  task automatic issueCmd(input logic w, input logic [AW-1:0] base, input logic [AW:0] len);
    int start;
    start     = acc_cnt;
    cmd_write = w;
    cmd_base  = base;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (acc_cnt != start) break;
    end
    checkOutput("cmd_accept", 32'(acc_cnt), 32'(start + 1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'b1;
    cmd_base  = 7'h55;
    cmd_len   = 8'd9;
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk); #1;
    end
    checkOutput("done_count", 32'(done_cnt), 32'(target));
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [AW-1:0] base, input logic [AW:0] len);
    int target;
    target = done_cnt + 1;
    issueCmd(w, base, len);
    waitDone(target);
  endtask

  initial begin
    int w0, x0, d0, s0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hC0DE0000 | 32'(i);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back, no backpressure
    queueWords(32'hA0, 4);
    w0 = we_cnt;
    applyStimulus(1'b1, 7'h10, 8'd4);
    checkOutput("t1_we_count", 32'(we_cnt - w0), 32'd4);
    checkOutput("t1_mem10", mem[7'h10], 32'hA0);
    checkOutput("t1_mem13", mem[7'h13], 32'hA3);
    rd_log.delete();
    applyStimulus(1'b0, 7'h10, 8'd4);
    checkOutput("t1_first_valid_lat", 32'(first_valid_n - acc_n), 32'd2);
    checkOutput("t1_back_to_back", 32'(last_xfer_n - first_xfer_n), 32'd3);
    checkOutput("t1_rd0", rd_log[0], 32'hA0);
    checkOutput("t1_rd3", rd_log[3], 32'hA3);

    // Wrap across the top of the RAM
    queueWords(32'd1, 4);
    applyStimulus(1'b1, 7'h7E, 8'd4);
    checkOutput("wrap_mem7e", mem[7'h7E], 32'd1);
    checkOutput("wrap_mem7f", mem[7'h7F], 32'd2);
    checkOutput("wrap_mem00", mem[7'h00], 32'd3);
    checkOutput("wrap_mem01", mem[7'h01], 32'd4);
    rd_log.delete();
    applyStimulus(1'b0, 7'h7E, 8'd4);
    checkOutput("wrap_rd2", rd_log[2], 32'd3);
    checkOutput("wrap_rd3", rd_log[3], 32'd4);

    // Read backpressure
    rd_log.delete();
    s0 = stall_cnt;
    rd_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rd_idx = 0;
    applyStimulus(1'b0, 7'h10, 8'd3);
    checkOutput("bp_stalled", 32'(stall_cnt > s0), 32'd1);
    checkOutput("bp_count", 32'(rd_log.size()), 32'd3);
    checkOutput("bp_rd1", rd_log[1], 32'hA1);
    checkOutput("bp_rd2", rd_log[2], 32'hA2);
    checkOutput("bp_done_after_last", 32'(done_n), 32'(last_xfer_n + 1));

    // Write stream with gaps
    gap_mode = 1;
    queueWords(32'hB0, 4);
    w0 = we_cnt;
    applyStimulus(1'b1, 7'h20, 8'd4);
    gap_mode = 0;
    checkOutput("gap_we_count", 32'(we_cnt - w0), 32'd4);
    checkOutput("gap_mem23", mem[7'h23], 32'hB3);

    // Zero length, write and read
    w0 = we_cnt;
    x0 = xfer_cnt;
    applyStimulus(1'b1, 7'h30, 8'd0);
    checkOutput("len0w_done_lat", 32'(done_n - acc_n), 32'd1);
    applyStimulus(1'b0, 7'h30, 8'd0);
    checkOutput("len0r_done_lat", 32'(done_n - acc_n), 32'd1);
    checkOutput("len0_no_writes", 32'(we_cnt - w0), 32'd0);
    checkOutput("len0_no_reads", 32'(xfer_cnt - x0), 32'd0);

    // Full-depth read and saturated length
    rd_log.delete();
    applyStimulus(1'b0, 7'h05, 8'd128);
    checkOutput("full_beats", 32'(cmd_xfers), 32'd128);
    checkOutput("full_rd0", rd_log[0], 32'hC0DE0005);
    checkOutput("full_rd11", rd_log[11], 32'hA0);
    checkOutput("full_rd127", rd_log[127], 32'hC0DE0004);
    rd_log.delete();
    applyStimulus(1'b0, 7'h40, 8'd200);
    checkOutput("sat_beats", 32'(cmd_xfers), 32'd128);
    checkOutput("sat_rd0", rd_log[0], 32'hC0DE0040);

    // Reset in the middle of a write
    queueWords(32'hD0, 5);
    w0 = we_cnt;
    d0 = done_cnt;
    issueCmd(1'b1, 7'h40, 8'd5);
    for (int i = 0; i < 50; i++) begin
      if (we_cnt - w0 >= 2) break;
      @(posedge clk);
    end
    checkOutput("mid_we_before_rst", 32'(we_cnt - w0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("mid_ram_we", 32'(ram_we), 32'd0);
    wr_feed.delete();
    wr_plan.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_rd.delete();
    model_active = 0;
    wr_pop = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_no_done", 32'(done_cnt), 32'(d0));
    checkOutput("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_mem42_untouched", mem[7'h42], 32'hC0DE0042);
    rd_log.delete();
    applyStimulus(1'b0, 7'h40, 8'd2);
    checkOutput("mid_rd0", rd_log[0], 32'hD0);
    checkOutput("mid_rd1", rd_log[1], 32'hD1);

    // A second command held during an active read
    rd_log.delete();
    d0 = done_cnt;
    issueCmd(1'b0, 7'h10, 8'd4);
    issueCmd(1'b0, 7'h7E, 8'd2);
    checkOutput("gate_first_done", 32'(done_cnt), 32'(d0 + 1));
    checkOutput("gate_accept_after_done", 32'(acc_n), 32'(done_n + 1));
    waitDone(d0 + 2);
    checkOutput("gate_count", 32'(rd_log.size()), 32'd6);
    checkOutput("gate_rd3", rd_log[3], 32'hA3);
    checkOutput("gate_rd4", rd_log[4], 32'd1);
    checkOutput("gate_rd5", rd_log[5], 32'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
